// File: rtl/flash_selftest_pkg.sv
// Shared definitions for the SPI-flash read self-test sequencer.
// Holds the sequencer state encoding, the per-lane RGB colour codes,
// the byte-lane count, and helpers that map state and fail bits onto
// the status outputs.
package flash_selftest_pkg;

   localparam int LANES = 4;

   localparam logic [2:0] RGB_PASS = 3'b010;
   localparam logic [2:0] RGB_FAIL = 3'b100;
   localparam logic [2:0] RGB_PEND = 3'b001;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_IDLE = 3'd1,
      ISSUE     = 3'd2,
      WAIT      = 3'd3,
      DONE      = 3'd4
   } state_t;

   // External state code: WAIT_IDLE and ISSUE both report as "issuing".
   function automatic logic [1:0] state_code(input state_t s);
      logic [1:0] code;
      case (s)
         IDLE:             code = 2'd0;
         WAIT_IDLE, ISSUE: code = 2'd1;
         WAIT:             code = 2'd2;
         DONE:             code = 2'd3;
         default:          code = 2'd0;
      endcase
      return code;
   endfunction

   // Final verdict colours: red for any failing lane, green otherwise.
   function automatic logic [3*LANES-1:0] lane_colours(input logic [LANES-1:0] fail);
      logic [3*LANES-1:0] rgb;
      rgb = '0;
      for (int k = 0; k < LANES; k++) begin
         rgb[3*k +: 3] = fail[k] ? RGB_FAIL : RGB_PASS;
      end
      return rgb;
   endfunction

endpackage

// File: rtl/flash_lane_cmp.sv
// Combinational byte-lane checker.
// Ports: data     - 32-bit word, lane k = data[8k+7:8k]
//        mismatch - bit k set when lane k differs from EXP_BYTE
//        count    - number of mismatching lanes (0..4)
module flash_lane_cmp
   import flash_selftest_pkg::*;
#(
   parameter logic [7:0] EXP_BYTE = 8'h31
) (
   input  logic [31:0]      data,
   output logic [LANES-1:0] mismatch,
   output logic [2:0]       count
);

   // Per-lane compare and popcount of the mismatches.
   always_comb begin
      mismatch = '0;
      count    = 3'd0;
      for (int k = 0; k < LANES; k++) begin
         mismatch[k] = (data[8*k +: 8] != EXP_BYTE);
         count       = count + {2'b00, mismatch[k]};
      end
   end

endmodule

// File: rtl/flash_selftest_seq.sv
// SPI-flash read self-test sequencer.
// Issues WORDS sequential 32-bit reads from BASE_ADDR, checks every byte
// lane against EXP_BYTE and reports a per-lane RGB verdict, an error count
// and a lost-response flag. One-shot on start, or free-running if REPEAT.
// Ports: clk100mhz/rst_n clock and async reset; start pass trigger;
//        phy_tx/phy_addr/phy_len read request; phy_busy/phy_valid/phy_data
//        PHY status and response; lane_rgb/err_cnt/timeout/done/state_o status.
module flash_selftest_seq
   import flash_selftest_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR   = 24'h400000,
   parameter int          WORDS       = 4,
   parameter logic [3:0]  PHY_LEN     = 4'd2,
   parameter logic [7:0]  EXP_BYTE    = 8'h31,
   parameter int          TIMEOUT_CYC = 4096,
   parameter bit          REPEAT      = 1'b0,
   parameter int          GAP_CYC     = 1000000
) (
   input  logic        clk100mhz,
   input  logic        rst_n,
   input  logic        start,
   output logic        phy_tx,
   output logic [23:0] phy_addr,
   output logic [3:0]  phy_len,
   input  logic        phy_busy,
   input  logic        phy_valid,
   input  logic [31:0] phy_data,
   output logic [11:0] lane_rgb,
   output logic [15:0] err_cnt,
   output logic        timeout,
   output logic        done,
   output logic [1:0]  state_o
);

   localparam int IW = (WORDS > 1)       ? $clog2(WORDS)       : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int GW = (GAP_CYC > 1)     ? $clog2(GAP_CYC)     : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   state_t          state_r, state_next_s;
   logic [IW-1:0]   idx_r;
   logic [TW-1:0]   timer_r;
   logic [GW-1:0]   gap_r;
   logic [LANES-1:0] fail_r, fail_next_s;
   logic [15:0]     perr_r, perr_next_s;
   logic [16:0]     perr_sum_s;
   logic [LANES-1:0] cmp_mis_s;
   logic [2:0]      cmp_cnt_s;
   logic            rsp_s, tmo_s, pass_start_s, done_entry_s;
   logic [23:0]     issue_addr_s;

   logic            phy_tx_r, timeout_r, done_r;
   logic [23:0]     phy_addr_r;
   logic [11:0]     lane_rgb_r;
   logic [15:0]     err_cnt_r;
   logic [1:0]      state_o_r;

   flash_lane_cmp #(.EXP_BYTE(EXP_BYTE)) u_cmp (
      .data     (phy_data),
      .mismatch (cmp_mis_s),
      .count    (cmp_cnt_s)
   );

   assign rsp_s        = (state_r == WAIT) && phy_valid;
   // A response on the last timer cycle still counts as a response.
   assign tmo_s        = (state_r == WAIT) && !phy_valid && (timer_r == TMR_LAST);
   assign pass_start_s = (state_next_s == WAIT_IDLE) && ((state_r == IDLE) || (state_r == DONE));
   assign done_entry_s = (state_next_s == DONE) && (state_r != DONE);
   assign perr_sum_s   = {1'b0, perr_r} + {14'b0, cmp_cnt_s};
   assign issue_addr_s = BASE_ADDR + {22'(idx_r), 2'b00};

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = WAIT_IDLE;
            else       state_next_s = IDLE;
         end
         WAIT_IDLE: begin
            if (!phy_busy) state_next_s = ISSUE;
            else           state_next_s = WAIT_IDLE;
         end
         ISSUE: state_next_s = WAIT;
         WAIT: begin
            if (rsp_s) begin
               if (idx_r == IDX_LAST) state_next_s = DONE;
               else                   state_next_s = WAIT_IDLE;
            end else if (tmo_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = WAIT;
            end
         end
         DONE: begin
            if (REPEAT) begin
               if (gap_r == GAP_LAST) state_next_s = WAIT_IDLE;
               else                   state_next_s = DONE;
            end else begin
               if (start) state_next_s = WAIT_IDLE;
               else       state_next_s = DONE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Lane verdict and error accumulation for the current cycle.
   always_comb begin
      fail_next_s = fail_r;
      perr_next_s = perr_r;
      if (rsp_s) begin
         fail_next_s = fail_r | cmp_mis_s;
         perr_next_s = perr_sum_s[16] ? 16'hFFFF : perr_sum_s[15:0];
      end else if (tmo_s) begin
         // The lost word's lanes were never sampled, so none can be trusted.
         fail_next_s = '1;
         perr_next_s = perr_r;
      end else begin
         fail_next_s = fail_r;
         perr_next_s = perr_r;
      end
   end

   // State register.
   always_ff @(posedge clk100mhz or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_next_s;
   end

   // Pass bookkeeping: word index, lane fail bits, error sum, timers.
   always_ff @(posedge clk100mhz or negedge rst_n) begin
      if (!rst_n) begin
         idx_r     <= '0;
         fail_r    <= '0;
         perr_r    <= 16'd0;
         timer_r   <= '0;
         gap_r     <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (pass_start_s) begin
            idx_r     <= '0;
            fail_r    <= '0;
            perr_r    <= 16'd0;
            timeout_r <= 1'b0;
         end else begin
            if (rsp_s && (idx_r != IDX_LAST)) idx_r <= idx_r + IW'(1);
            fail_r <= fail_next_s;
            perr_r <= perr_next_s;
            if (tmo_s) timeout_r <= 1'b1;
         end
         if (state_r == ISSUE)     timer_r <= '0;
         else if (state_r == WAIT) timer_r <= timer_r + TW'(1);
         if (state_r == DONE) gap_r <= gap_r + GW'(1);
         else                 gap_r <= '0;
      end
   end

   // Registered outputs, derived from the state being entered.
   always_ff @(posedge clk100mhz or negedge rst_n) begin
      if (!rst_n) begin
         phy_tx_r   <= 1'b0;
         phy_addr_r <= BASE_ADDR;
         lane_rgb_r <= {LANES{RGB_PEND}};
         err_cnt_r  <= 16'd0;
         done_r     <= 1'b0;
         state_o_r  <= 2'd0;
      end else begin
         phy_tx_r <= (state_next_s == ISSUE);
         if (state_next_s == ISSUE) phy_addr_r <= issue_addr_s;
         if (pass_start_s) begin
            lane_rgb_r <= {LANES{RGB_PEND}};
         end else if (done_entry_s) begin
            lane_rgb_r <= lane_colours(fail_next_s);
            err_cnt_r  <= perr_next_s;
         end
         done_r    <= (state_next_s == DONE);
         state_o_r <= state_code(state_next_s);
      end
   end

   assign phy_tx   = phy_tx_r;
   assign phy_addr = phy_addr_r;
   assign phy_len  = PHY_LEN;
   assign lane_rgb = lane_rgb_r;
   assign err_cnt  = err_cnt_r;
   assign timeout  = timeout_r;
   assign done     = done_r;
   assign state_o  = state_o_r;

endmodule

// File: tb/tb_flash_selftest_seq.sv
// Directed bench for flash_selftest_seq with a behavioural PHY model.
// dut_a is one-shot (default parameters); dut_b free-runs with a short gap.
module tb_flash_selftest_seq;

   localparam logic [23:0] BASE = 24'h400000;

   logic clk100mhz = 1'b0;
   always #5 clk100mhz = ~clk100mhz;

   logic        rst_n, start, phy_busy, phy_valid;
   logic [31:0] phy_data;
   logic        phy_tx, timeout, done;
   logic [23:0] phy_addr;
   logic [3:0]  phy_len;
   logic [11:0] lane_rgb;
   logic [15:0] err_cnt;
   logic [1:0]  state_o;

   logic        b_start, b_busy, b_valid;
   logic [31:0] b_data;
   logic        b_tx, b_timeout, b_done;
   logic [23:0] b_addr;
   logic [3:0]  b_len;
   logic [11:0] b_rgb;
   logic [15:0] b_err;
   logic [1:0]  b_state;

   flash_selftest_seq #(.REPEAT(1'b0)) dut_a (
      .clk100mhz(clk100mhz), .rst_n(rst_n), .start(start),
      .phy_tx(phy_tx), .phy_addr(phy_addr), .phy_len(phy_len),
      .phy_busy(phy_busy), .phy_valid(phy_valid), .phy_data(phy_data),
      .lane_rgb(lane_rgb), .err_cnt(err_cnt), .timeout(timeout),
      .done(done), .state_o(state_o)
   );

   flash_selftest_seq #(.REPEAT(1'b1), .GAP_CYC(100)) dut_b (
      .clk100mhz(clk100mhz), .rst_n(rst_n), .start(b_start),
      .phy_tx(b_tx), .phy_addr(b_addr), .phy_len(b_len),
      .phy_busy(b_busy), .phy_valid(b_valid), .phy_data(b_data),
      .lane_rgb(b_rgb), .err_cnt(b_err), .timeout(b_timeout),
      .done(b_done), .state_o(b_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [23:0] qa[$];
   logic [23:0] qb[$];

   logic [31:0] data_tab [4];
   int  drop_word = -1;
   int  lat = 20;
   bit  a_pend = 1'b0;
   int  a_cnt = 0;
   int  a_word = 0;
   int  tx_seen = 0;
   int  first_tx = 0;
   bit  b_pend = 1'b0;
   int  b_cnt = 0;
   bit  b_bad = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample DUTs just after the edge, then run the PHY models.
   task automatic tick();
      logic [23:0] exp_addr;
      logic [23:0] off;
      @(posedge clk100mhz);
      #1;
      cyc++;
      phy_valid = 1'b0;
      if (a_pend) begin
         if (a_cnt == 0) begin
            phy_valid = 1'b1;
            phy_data  = data_tab[a_word];
            a_pend    = 1'b0;
         end else begin
            a_cnt--;
         end
      end
      if (phy_tx) begin
         if (qa.size() == 0) begin
            check("a_spurious_phy_tx", {31'b0, phy_tx}, 32'd0);
         end else begin
            exp_addr = qa.pop_front();
            check("a_phy_addr", {8'b0, phy_addr}, {8'b0, exp_addr});
            if (tx_seen == 0) first_tx = cyc;
            tx_seen++;
            off    = phy_addr - BASE;
            a_word = int'(off[3:2]);
            if (a_word != drop_word) begin
               a_pend = 1'b1;
               a_cnt  = lat - 1;
            end
         end
      end
      b_valid = 1'b0;
      if (b_pend) begin
         if (b_cnt == 0) begin
            b_valid = 1'b1;
            b_data  = b_bad ? 32'h31313100 : 32'h31313131;
            b_pend  = 1'b0;
         end else begin
            b_cnt--;
         end
      end
      if (b_tx) begin
         if (qb.size() == 0) begin
            check("b_spurious_phy_tx", {31'b0, b_tx}, 32'd0);
         end else begin
            exp_addr = qb.pop_front();
            check("b_phy_addr", {8'b0, b_addr}, {8'b0, exp_addr});
            b_pend = 1'b1;
            b_cnt  = 4;
         end
      end
   endtask

   task automatic pulse_start_a();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done_a(input string tag, input int bound);
      int n = 0;
      while (done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      check({tag, "_done"}, {31'b0, done}, 32'd1);
   endtask

   task automatic wait_done_b(input string tag, input int bound);
      int n = 0;
      while (b_done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      check({tag, "_done"}, {31'b0, b_done}, 32'd1);
   endtask

   task automatic push_words_a(input int n);
      for (int i = 0; i < n; i++) qa.push_back(BASE + 24'(4 * i));
   endtask

   initial begin
      int s, f, n;
      rst_n = 1'b0; start = 1'b0; phy_busy = 1'b0; phy_valid = 1'b0; phy_data = 32'd0;
      b_start = 1'b0; b_busy = 1'b0; b_valid = 1'b0; b_data = 32'd0;
      for (int i = 0; i < 4; i++) data_tab[i] = 32'h31313131;
      repeat (3) tick();

      // Reset values.
      check("rst_phy_tx",   {31'b0, phy_tx},  32'd0);
      check("rst_phy_addr", {8'b0, phy_addr}, 32'h00400000);
      check("rst_lane_rgb", {20'b0, lane_rgb}, 32'h249);
      check("rst_err_cnt",  {16'b0, err_cnt}, 32'd0);
      check("rst_timeout",  {31'b0, timeout}, 32'd0);
      check("rst_done",     {31'b0, done},    32'd0);
      check("rst_state",    {30'b0, state_o}, 32'd0);
      check("phy_len",      {28'b0, phy_len}, 32'd2);
      rst_n = 1'b1;
      repeat (2) tick();

      // Clean pass: four reads, all lanes green.
      push_words_a(4);
      tx_seen = 0;
      s = cyc;
      pulse_start_a();
      check("t1_pending_rgb", {20'b0, lane_rgb}, 32'h249);
      check("t1_done_low",    {31'b0, done},     32'd0);
      wait_done_a("t1", 400);
      check("t1_latency",  first_tx - s, 32'd2);
      check("t1_all_tx",   qa.size(), 32'd0);
      check("t1_lane_rgb", {20'b0, lane_rgb}, 32'h492);
      check("t1_err_cnt",  {16'b0, err_cnt}, 32'd0);
      check("t1_timeout",  {31'b0, timeout}, 32'd0);
      check("t1_state",    {30'b0, state_o}, 32'd3);

      // Word 2 has a bad byte on lane 2 only: lanes {3,2,1,0} = 010 100 010 010.
      data_tab[2] = 32'h31FF3131;
      push_words_a(4);
      pulse_start_a();
      wait_done_a("t2", 400);
      check("t2_lane_rgb", {20'b0, lane_rgb}, 32'h512);
      check("t2_err_cnt",  {16'b0, err_cnt}, 32'd1);
      data_tab[2] = 32'h31313131;

      // PHY busy after start: the first strobe waits for busy to fall.
      push_words_a(4);
      tx_seen = 0;
      phy_busy = 1'b1;
      pulse_start_a();
      repeat (48) tick();
      check("t3_no_tx_busy", tx_seen, 32'd0);
      phy_busy = 1'b0;
      f = cyc;
      wait_done_a("t3", 400);
      check("t3_tx_after_busy", first_tx - f, 32'd1);
      check("t3_all_tx",   qa.size(), 32'd0);
      check("t3_lane_rgb", {20'b0, lane_rgb}, 32'h492);

      // Word 1 lost; word 0 carries one bad byte. All lanes red, no more reads.
      data_tab[0] = 32'h31313100;
      drop_word = 1;
      push_words_a(2);
      pulse_start_a();
      wait_done_a("t4", 4400);
      check("t4_timeout",  {31'b0, timeout}, 32'd1);
      check("t4_lane_rgb", {20'b0, lane_rgb}, 32'h924);
      check("t4_err_cnt",  {16'b0, err_cnt}, 32'd1);
      repeat (60) tick();
      check("t4_all_tx", qa.size(), 32'd0);
      drop_word = -1;
      data_tab[0] = 32'h31313131;

      // Reset while waiting on word 1; its late response must be ignored.
      push_words_a(2);
      tx_seen = 0;
      pulse_start_a();
      n = 0;
      while (tx_seen < 2 && n < 40) begin
         tick();
         n++;
      end
      check("t5_second_tx", tx_seen, 32'd2);
      repeat (5) tick();
      check("t5_state_wait", {30'b0, state_o}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_state",   {30'b0, state_o}, 32'd0);
      check("t5_rst_addr",    {8'b0, phy_addr}, 32'h00400000);
      check("t5_rst_err_cnt", {16'b0, err_cnt}, 32'd0);
      check("t5_rst_phy_tx",  {31'b0, phy_tx},  32'd0);
      check("t5_rst_rgb",     {20'b0, lane_rgb}, 32'h249);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (30) tick();
      check("t5_post_state", {30'b0, state_o}, 32'd0);
      check("t5_post_done",  {31'b0, done},    32'd0);
      check("t5_post_err",   {16'b0, err_cnt}, 32'd0);
      check("t5_post_rgb",   {20'b0, lane_rgb}, 32'h249);

      // Free-running instance: bad lane 0 on pass 1, clean pass 2, gap of 100.
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 4; i++) qb.push_back(BASE + 24'(4 * i));
      b_bad = 1'b1;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      wait_done_b("b1", 400);
      check("b1_err_cnt",  {16'b0, b_err}, 32'd4);
      check("b1_lane_rgb", {20'b0, b_rgb}, 32'h494);
      b_bad = 1'b0;
      n = 0;
      while (b_done === 1'b1 && n < 300) begin
         n++;
         tick();
      end
      check("b_gap_cycles", n, 32'd100);
      check("b2_pending_rgb", {20'b0, b_rgb}, 32'h249);
      check("b2_err_held",    {16'b0, b_err}, 32'd4);
      wait_done_b("b2", 400);
      check("b2_err_cnt",  {16'b0, b_err}, 32'd0);
      check("b2_lane_rgb", {20'b0, b_rgb}, 32'h492);
      check("b2_all_tx",   qb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
